// File: rtl/cpu8_pkg.sv
// Shared constants and types for the 8-bit CPU datapath blocks.
package cpu8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEBOUNCE_HI = 2'd1,
    WRITE       = 2'd2,
    DEBOUNCE_LO = 2'd3
  } prog_state_t;

endpackage

// File: rtl/button_debounce.sv
// Program-button conditioner: 2-flop synchronizer, press/release debounce
// counter and an FSM that emits exactly one press pulse per physical press.
module button_debounce
  import cpu8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn,
  output logic press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  prog_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign btn_s = sync_q[1];

  // Bring the raw asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], btn};
  end

  // Next-state logic; losing the enable aborts any press in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (btn_s) state_d = DEBOUNCE_HI;
        end
        DEBOUNCE_HI: begin
          if (!btn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = WRITE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          state_d = DEBOUNCE_LO;
          cnt_d   = '0;
        end
        DEBOUNCE_LO: begin
          if (btn_s) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate with en so a mode switch during WRITE never commits a write.
  assign press = (state_q == WRITE) && en;

endmodule

// File: rtl/ram16_mar.sv
// 16x8 RAM with memory address register for the 8-bit CPU, plus a
// debounced switch/button path for hand-entering programs while halted.
module ram16_mar
  import cpu8_pkg::*;
#(
  parameter int DATA_W          = cpu8_pkg::DATA_W,
  parameter int ADDR_W          = cpu8_pkg::ADDR_W,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_load,
  input  logic              ram_write,
  input  logic              ram_out,
  input  logic              prog_mode,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_btn,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_out_valid,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] ram_q,
  output logic              prog_ack
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              cpu_en;
  logic              prog_we;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  assign cpu_en = step && !prog_mode;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (prog_mode),
    .btn  (prog_btn),
    .press(prog_we)
  );

  assign prog_ack = prog_we;

  // Single write port shared by the CPU and the programming switches; the
  // two sources are mutually exclusive through prog_mode.
  assign we = (cpu_en && ram_write) || prog_we;
  assign wa = prog_mode ? prog_addr : mar_q;
  assign wd = prog_mode ? prog_data : bus_in;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // CPU-side registers; all actions use the pre-edge MAR (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar_q         <= '0;
      bus_out       <= '0;
      bus_out_valid <= 1'b0;
    end else if (cpu_en) begin
      if (mar_load) mar_q <= bus_in[ADDR_W-1:0];
      if (ram_out)  bus_out <= mem[mar_q];
      bus_out_valid <= ram_out;
    end
  end

  // Asynchronous read for the LED view.
  assign ram_q = prog_mode ? mem[prog_addr] : mem[mar_q];

endmodule

// File: tb/tb_ram16_mar.sv
// Directed bench for ram16_mar: stimulus queues expected values tagged with
// the cycle they must appear in; a negedge monitor pops and compares.
module tb_ram16_mar;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step;
  logic [7:0] bus_in;
  logic       mar_load, ram_write, ram_out;
  logic       prog_mode;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_btn;
  logic [7:0] bus_out;
  logic       bus_out_valid;
  logic [3:0] mar_q;
  logic [7:0] ram_q;
  logic       prog_ack;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    int         sig;   // 0 mar_q, 1 bus_out, 2 bus_out_valid, 3 ram_q
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];

  ram16_mar #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .bus_in(bus_in),
    .mar_load(mar_load), .ram_write(ram_write), .ram_out(ram_out),
    .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_btn(prog_btn), .bus_out(bus_out), .bus_out_valid(bus_out_valid),
    .mar_q(mar_q), .ram_q(ram_q), .prog_ack(prog_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare queued expectations and every prog_ack pulse.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t       e;
      logic [7:0] act;
      e = exp_q.pop_front();
      case (e.sig)
        0:       act = {4'h0, mar_q};
        1:       act = bus_out;
        2:       act = {7'h00, bus_out_valid};
        default: act = ram_q;
      endcase
      tests++;
      if (e.cyc != cyc || act !== e.val) begin
        fails++;
        $display("FAIL %s: cyc %0d got %h, expected %h (due cyc %0d)",
                 e.name, cyc, act, e.val, e.cyc);
      end
    end
    while (ack_q.size() > 0 && ack_q[0] < cyc) begin
      tests++;
      fails++;
      $display("FAIL prog_ack_missing: no ack seen, expected in cyc %0d", ack_q.pop_front());
    end
    if (prog_ack === 1'b1) begin
      tests++;
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
        void'(ack_q.pop_front());
      end else begin
        fails++;
        $display("FAIL prog_ack_unexpected: ack in cyc %0d, expected none", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int sig, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic cpu_step(input logic mi, input logic ri, input logic ro, input logic [7:0] d);
    step = 1'b1; mar_load = mi; ram_write = ri; ram_out = ro; bus_in = d;
    tick();
    step = 1'b0; mar_load = 1'b0; ram_write = 1'b0; ram_out = 1'b0;
  endtask

  initial begin
    logic bounce [5];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; step = 1'b0; bus_in = 8'h00; mar_load = 1'b0;
    ram_write = 1'b0; ram_out = 1'b0; prog_mode = 1'b0;
    prog_addr = 4'h0; prog_data = 8'h00; prog_btn = 1'b0;

    // Reset state
    tick(); tick();
    expect_now(0, 8'h00, "rst_mar");
    expect_now(1, 8'h00, "rst_bus_out");
    expect_now(2, 8'h00, "rst_valid");
    rst_n = 1'b1;
    tick();

    // MAR load
    cpu_step(1, 0, 0, 8'h0A);
    expect_now(0, 8'h0A, "mar_load_0a");
    expect_now(1, 8'h00, "mar_load_bus_out");
    expect_now(2, 8'h00, "mar_load_valid");

    // Preload mem[3] = 0x33
    cpu_step(1, 0, 0, 8'h03);
    expect_now(0, 8'h03, "mar_load_03");
    cpu_step(0, 1, 0, 8'h33);
    expect_now(3, 8'h33, "ram_q_mem3_pre");
    expect_now(2, 8'h00, "write_only_valid");

    // Read-before-write on the same step
    cpu_step(0, 1, 1, 8'h5C);
    expect_now(1, 8'h33, "rbw_old_data");
    expect_now(2, 8'h01, "rbw_valid");
    expect_now(3, 8'h5C, "rbw_ram_q_new");
    tick();
    expect_now(1, 8'h33, "hold_no_step_bus");
    expect_now(2, 8'h01, "hold_no_step_valid");
    cpu_step(0, 0, 1, 8'h00);
    expect_now(1, 8'h5C, "read_new_data");
    expect_now(2, 8'h01, "read_new_valid");
    cpu_step(0, 0, 0, 8'h00);
    expect_now(2, 8'h00, "no_ro_valid_low");
    expect_now(1, 8'h5C, "no_ro_bus_hold");

    // Upper bus bits ignored on MAR load
    cpu_step(1, 0, 0, 8'hF7);
    expect_now(0, 8'h07, "mar_load_f7");
    cpu_step(0, 1, 0, 8'h11);
    expect_now(3, 8'h11, "ram_q_mem7");
    cpu_step(0, 0, 1, 8'h00);
    expect_now(1, 8'h11, "read_mem7");
    expect_now(2, 8'h01, "read_mem7_valid");

    // Clean press: ack in cycle 7 relative to press, once
    prog_mode = 1'b1; prog_addr = 4'h7; prog_data = 8'hE1;
    repeat (3) tick();
    expect_now(3, 8'h11, "prog_view_before");
    prog_btn = 1'b1;
    ack_q.push_back(cyc + 7);
    repeat (50) tick();
    expect_now(3, 8'hE1, "prog_write_e1");
    prog_btn = 1'b0;
    repeat (10) tick();

    // Bouncing press: ack 7 cycles after final rising edge
    prog_addr = 4'h2; prog_data = 8'h9B;
    for (int i = 0; i < 5; i++) begin
      prog_btn = bounce[i];
      tick();
    end
    prog_btn = 1'b1;
    ack_q.push_back(cyc + 7);
    repeat (20) tick();
    expect_now(3, 8'h9B, "prog_write_bounce");
    prog_btn = 1'b0;
    repeat (10) tick();

    // CPU controls ignored in programming mode
    prog_addr = 4'h7;
    step = 1'b1; mar_load = 1'b1; ram_write = 1'b1; ram_out = 1'b0; bus_in = 8'hFF;
    tick();
    step = 1'b0; mar_load = 1'b0; ram_write = 1'b0;
    expect_now(0, 8'h07, "prog_mode_mar_hold");
    expect_now(1, 8'h11, "prog_mode_bus_hold");
    expect_now(2, 8'h01, "prog_mode_valid_hold");
    expect_now(3, 8'hE1, "prog_mode_ram_hold");
    tick();
    prog_mode = 1'b0;
    expect_now(3, 8'hE1, "cpu_view_mem7");

    // Reset during DEBOUNCE_HI: no write
    tick();
    prog_mode = 1'b1; prog_data = 8'h00;
    tick();
    prog_btn = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0; prog_btn = 1'b0;
    tick();
    expect_now(0, 8'h00, "mid_rst_mar");
    expect_now(1, 8'h00, "mid_rst_bus_out");
    expect_now(2, 8'h00, "mid_rst_valid");
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    expect_now(3, 8'hE1, "rst_abort_keeps_mem7");

    // prog_mode dropped during DEBOUNCE_HI: no write
    prog_btn = 1'b1;
    repeat (5) tick();
    prog_mode = 1'b0;
    repeat (20) tick();
    prog_btn = 1'b0;
    repeat (5) tick();
    prog_mode = 1'b1;
    tick();
    expect_now(3, 8'hE1, "mode_abort_keeps_mem7");

    repeat (3) tick();
    tests++;
    if (ack_q.size() != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d acks and %0d values pending, expected 0",
               ack_q.size(), exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
